// File: rtl/dmem_subword.sv
// dmem_subword: single-port data memory with byte/half/word access, one
// outstanding request and a fixed, parameterised response latency.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (control only; memory is kept)
//   req_valid    request present
//   req_ready    high in IDLE only; a request is taken when valid && ready
//   req_we       1 = store, 0 = load
//   req_addr     byte address (ADDR_W bits), little-endian lanes
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned load zero-extends when 1, sign-extends when 0
//   req_wdata    right-aligned store data
//   resp_valid   one-cycle pulse, LATENCY+1 cycles after accept
//   resp_rdata   load result (0 for stores, errors and when not valid)
//   resp_err     misaligned/illegal request flag, qualified by resp_valid
module dmem_subword #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  // WAIT lasts LATENCY cycles: counter runs LATENCY-1 .. 0 and RESP follows.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic                  accept;
  logic [ADDR_W-3:0]     widx;
  logic [1:0]            lane;
  logic                  misalign;
  logic [31:0]           rd_word;
  logic [31:0]           rdata_p1;
  logic                  err_p1;

  // Memory powers up cleared and is never touched by reset.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane_i);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane_i[0];
      2'b10:   bad = (lane_i != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane_i);
    logic [31:0] w;
    w = old;
    case (size)
      2'b00:   w[{lane_i, 3'b000} +: 8]     = wd[7:0];
      2'b01:   w[{lane_i[1], 4'b0000} +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane_i,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{lane_i, 3'b000} +: 8];
    h = w[{lane_i[1], 4'b0000} +: 16];
    case (size)
      2'b00: begin
        if (uns) r = {24'd0, b};
        else     r = 32'(b);
      end
      2'b01: begin
        if (uns) r = {16'd0, h};
        else     r = 32'(h);
      end
      default: r = w;
    endcase
    return r;
  endfunction

  assign widx     = req_addr[ADDR_W-1:2];
  assign lane     = req_addr[1:0];
  assign misalign = is_misaligned(req_size, lane);
  assign rd_word  = mem[widx];
  // Reset wins over a simultaneous request.
  assign accept   = req_valid && req_ready && !rst;

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = resp_valid ? rdata_p1 : 32'd0;
    resp_err   = resp_valid & err_p1;
  end

  // Accept edge: capture load result and error, commit store
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_p1 <= (misalign || req_we) ? 32'd0
                                       : load_extend(rd_word, req_size, lane, req_unsigned);
      err_p1   <= misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !misalign)
      mem[widx] <= store_merge(rd_word, req_wdata, req_size, lane);
  end

endmodule

// File: tb/tb_dmem_subword.sv
// tb_dmem_subword: drives two dmem_subword instances (LATENCY 0 and 3) with
// a directed sequence; expected responses are queued at issue time and
// popped by per-instance monitors when resp_valid is seen.
module tb_dmem_subword;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [5:0]  req_addr     [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic armed  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_subword #(.ADDR_W(6), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_subword #(.ADDR_W(6), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic observe(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (resp_valid[d] === 1'b1) begin
      n_chk++;
      assert (sz != 0) else begin
        n_fail++;
        $error("FAIL d%0d_unexpected_resp: observed resp_valid=1 at cycle %0d expected 0", d, cyc);
      end
      if (sz != 0) begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("d%0d_resp_cycle", d), 32'(cyc), 32'(e.cyc));
        check($sformatf("d%0d_rdata", d), resp_rdata[d], e.rd);
        check($sformatf("d%0d_err", d), {31'd0, resp_err[d]}, {31'd0, e.err});
      end
    end else begin
      check($sformatf("d%0d_idle_rdata", d), resp_rdata[d], 32'd0);
      check($sformatf("d%0d_idle_err", d), {31'd0, resp_err[d]}, 32'd0);
    end
  endtask

  always @(negedge clk) if (armed) begin
    observe(0);
    observe(1);
  end

  task automatic drive(input int d, input logic we, input logic [5:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_addr[d]     = addr;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_wdata[d]    = wd;
  endtask

  task automatic push(input int d, input logic [31:0] rd, input logic err, input int at);
    exp_t e;
    e.rd = rd; e.err = err; e.cyc = at;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 40 && ((d == 0) ? q0.size() : q1.size()) != 0; i++)
      @(negedge clk);
    check($sformatf("d%0d_resp_timeout_pending", d), 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  // One request: issue in an IDLE cycle, expect response LATENCY+1 cycles later.
  task automatic issue(input int d, input logic we, input logic [5:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    lat = (d == 0) ? 0 : 3;
    @(negedge clk);
    drive(d, we, addr, size, uns, wd);
    check($sformatf("d%0d_ready_at_issue", d), {31'd0, req_ready[d]}, 32'd1);
    push(d, exp_rd, exp_err, cyc + lat + 1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = ~addr;
    req_wdata[d] = ~wd;
    drain(d);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_size[d] = 2'b00; req_unsigned[d] = 1'b0; req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check("d0_ready_after_reset", {31'd0, req_ready[0]}, 32'd1);
    check("d1_ready_after_reset", {31'd0, req_ready[1]}, 32'd1);
    check("d0_valid_after_reset", {31'd0, resp_valid[0]}, 32'd0);
    check("d1_valid_after_reset", {31'd0, resp_valid[1]}, 32'd0);
    armed = 1'b1;

    // LATENCY=0: word store/load, then sub-word stores and loads
    issue(0, 1'b0, 6'h30, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
    issue(0, 1'b1, 6'h08, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(0, 1'b0, 6'h08, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b1, 6'h0D, 2'b00, 1'b0, 32'hFFFF_FF80, 32'h0, 1'b0);
    issue(0, 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0, 32'h0000_8000, 1'b0);
    issue(0, 1'b0, 6'h0D, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0);
    issue(0, 1'b0, 6'h0D, 2'b00, 1'b1, 32'h0, 32'h0000_0080, 1'b0);
    issue(0, 1'b0, 6'h0C, 2'b01, 1'b0, 32'h0, 32'hFFFF_8000, 1'b0);
    issue(0, 1'b0, 6'h0C, 2'b01, 1'b1, 32'h0, 32'h0000_8000, 1'b0);
    issue(0, 1'b0, 6'h0B, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0);
    issue(0, 1'b0, 6'h08, 2'b00, 1'b1, 32'h0, 32'h0000_00EF, 1'b0);
    issue(0, 1'b0, 6'h0A, 2'b01, 1'b1, 32'h0, 32'h0000_DEAD, 1'b0);
    issue(0, 1'b1, 6'h0E, 2'b01, 1'b0, 32'hABCD_1234, 32'h0, 1'b0);
    issue(0, 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0, 32'h1234_8000, 1'b0);
    issue(0, 1'b1, 6'h3C, 2'b10, 1'b0, 32'h0BAD_F00D, 32'h0, 1'b0);
    issue(0, 1'b0, 6'h3C, 2'b10, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0);

    // Misaligned and illegal requests write nothing and return err
    issue(0, 1'b1, 6'h02, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(0, 1'b0, 6'h05, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 6'h08, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 6'h00, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(0, 1'b1, 6'h01, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(0, 1'b0, 6'h00, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);

    // LATENCY=3: busy window and held request
    issue(1, 1'b1, 6'h20, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 6'h20, 2'b10, 1'b0, 32'h0);
    check("d1_ready_T", {31'd0, req_ready[1]}, 32'd1);
    n = cyc;
    push(1, 32'hCAFE_F00D, 1'b0, n + 4);
    @(posedge clk);
    #1;
    drive(1, 1'b1, 6'h24, 2'b10, 1'b0, 32'h1212_1212);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("d1_ready_busy_T+%0d", k), {31'd0, req_ready[1]}, 32'd0);
    end
    @(negedge clk);
    check("d1_ready_T+5", {31'd0, req_ready[1]}, 32'd1);
    push(1, 32'h0, 1'b0, cyc + 4);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drain(1);
    issue(1, 1'b0, 6'h24, 2'b10, 1'b0, 32'h0, 32'h1212_1212, 1'b0);

    // LATENCY=3: reset during WAIT drops the response, keeps the store
    @(negedge clk);
    drive(1, 1'b1, 6'h3C, 2'b10, 1'b0, 32'h1234_5678);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("d1_ready_after_mid_reset", {31'd0, req_ready[1]}, 32'd1);
    repeat (5) @(negedge clk);
    issue(1, 1'b0, 6'h3C, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0);

    // Reset beats a simultaneous store
    @(negedge clk);
    rst[1] = 1'b1;
    drive(1, 1'b1, 6'h3C, 2'b10, 1'b0, 32'hFFFF_FFFF);
    @(negedge clk);
    rst[1] = 1'b0;
    req_valid[1] = 1'b0;
    check("d1_ready_after_req_in_reset", {31'd0, req_ready[1]}, 32'd1);
    repeat (5) @(negedge clk);
    issue(1, 1'b0, 6'h3C, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
    issue(1, 1'b0, 6'h30, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
